operand_fetch: RTL
==================

# operand_fetch

Decode-stage operand fetch unit for the 5-stage pipelined MIPS core. It is the read side of the 32×32 register file: it drives the two read addresses and takes the two read data buses. It resolves RAW hazards against instructions still in EX/MEM/WB by forwarding or by stalling. It registers the resolved operands into the ID/EX boundary behind a valid/ready handshake.

## Interface
- DW, 32, data width
- AW, 5, register address width (register 0 reads as constant 0)
- clk  in  1  clock, rising edge
- clrn  in  1  reset, asynchronous, active-low
- id_valid  in  1  decoded instruction present in ID
- id_rs, id_rt  in  AW  source register numbers
- id_use_rs, id_use_rt  in  1  instruction actually reads rs / rt
- id_wn  in  AW  destination register
- id_we  in  1  instruction writes id_wn
- id_isload  in  1  instruction is a load (result available only in MEM)
- id_ready  out  1  ID may advance this cycle; combinational
- rf_rna, rf_rnb  out  AW  register-file read addresses; combinational copies of id_rs / id_rt
- rf_qa, rf_qb  in  DW  register-file read data (combinational, register 0 = 0)
- ex_alu_res  in  DW  result of the instruction currently in EX
- mem_res  in  DW  result (ALU or load data) of the instruction in MEM
- wb_d  in  DW  value being written to the register file this cycle
- ex_ready  in  1  global pipeline enable; 0 freezes ID/EX and tracking
- ex_valid  out  1  ID/EX holds a real instruction
- ex_a, ex_b  out  DW  resolved operands
- ex_wn  out  AW, ex_we  out  1, ex_isload  out  1  forwarded control for EX

## Operation
- Tracking slots: EX = the ID/EX output register. MEM and WB are internal {valid, wn, we, isload} shift registers (EX→MEM→WB). They shift when ex_ready=1.
- A slot "matches" source s when slot valid, we=1, wn==s, s!=0, and the source is used.
- Forward priority per operand: EX (ex_alu_res) > MEM (mem_res) > WB (wb_d) > rf_qa/rf_qb. A source of 0 always yields 0.
- Load-use hazard: EX slot matches a used source and ex_isload=1. Response: id_ready=0, and a bubble is loaded into ID/EX (ex_valid=0, ex_we=0, ex_isload=0). The next cycle the load is in MEM and mem_res is forwarded.
- The three cases are selected on each ex_ready=1 edge:
  - id_valid=1 and no hazard: capture the resolved operands and control; ex_valid=1.
  - id_valid=0: load a bubble.
  - Hazard: load a bubble.
- ex_ready=0: all registers hold and id_ready=0.
- id_ready = ex_ready & ~hazard.
- Simultaneous match in EX and MEM for the same register: EX wins (youngest).
- An instruction with id_we=1 and id_wn=0 never creates a match.

## Timing
- Operands appear on ex_* one clk after the capturing edge.
- Load-use costs exactly one bubble cycle.
- Reset (clrn=0, asynchronous): ex_valid=0, ex_a=0, ex_b=0, ex_wn=0, ex_we=0, ex_isload=0, and all MEM/WB slots invalid.
- Reset mid-operation discards all in-flight tracking. The first instruction after reset reads only from the register file.
- WB forwarding is mandatory: the register file updates on the same edge that ID samples, so without it the stale value would be captured.

## Configuration
- OPERAND_FETCH_FWD_EN defined: full forwarding as above; the only stall is load-use.
- Not defined: no forwarding muxes. A match in any of EX/MEM/WB is a hazard, and bubbles are inserted until no slot matches. Operands come only from rf_qa/rf_qb.

## Structure
- operand_fetch_pkg: DW/AW localparams, REG_ZERO constant, and slot_t typedef {valid, wn, we, isload}.
- Sub-module fwd_sel: one operand's match detection and priority mux. It is instantiated twice (rs/qa, rt/qb). Under the non-forwarding build it reports match only.

## Test plan
- Back-to-back ALU dependency: add r3 writes with ex_alu_res=0x11; next instruction reads r3 while rf_qa=0 -> ex_a=0x11, no stall.
- Load-use: lw r5 in EX, next instruction reads r5 -> id_ready=0 for 1 cycle, one bubble. Then with mem_res=0xDEAD -> ex_b=0xDEAD.
- WB forward: r7 in WB with wb_d=0x77 and rf_qb=0x0 -> ex_b=0x77.
- Priority: r2 in EX (0xA) and in MEM (0xB) -> ex_a=0xA. Source r0 with an EX slot writing r0 -> ex_a=0.
- Freeze: ex_ready=0 for 3 cycles -> ex_* and slots unchanged, id_ready=0. Reset asserted mid-stream -> all outputs 0 immediately.
- Build without OPERAND_FETCH_FWD_EN: dependent ALU pair -> 3 bubbles, then ex_a equals the register-file value.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: widths, zero register and the EX/MEM/WB tracking slot shared by the operand fetch unit
package operand_fetch_pkg;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam logic [AW-1:0] REG_ZERO = '0;
   typedef struct packed {
      logic          valid;
      logic [AW-1:0] wn;
      logic          we;
      logic          isload;
   } slot_t;
   // A slot writing r0 can never be a producer, so it never matches.
   function automatic logic slot_match(slot_t s, logic [AW-1:0] src, logic use_src);
      return s.valid & s.we & use_src & (s.wn == src) & (src != REG_ZERO);
   endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: ID-side decode inputs, register-file read port and ID/EX outputs of the operand fetch unit
interface operand_fetch_if;
   import operand_fetch_pkg::*;
   logic          id_valid, id_use_rs, id_use_rt, id_we, id_isload, id_ready;
   logic [AW-1:0] id_rs, id_rt, id_wn, rf_rna, rf_rnb, ex_wn;
   logic [DW-1:0] rf_qa, rf_qb, ex_alu_res, mem_res, wb_d, ex_a, ex_b;
   logic          ex_ready, ex_valid, ex_we, ex_isload;
   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wn, id_we, id_isload,
      output rf_qa, rf_qb, ex_alu_res, mem_res, wb_d, ex_ready,
      input  id_ready, rf_rna, rf_rnb, ex_valid, ex_a, ex_b, ex_wn, ex_we, ex_isload
   );
   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wn, id_we, id_isload,
      input  rf_qa, rf_qb, ex_alu_res, mem_res, wb_d, ex_ready,
      output id_ready, rf_rna, rf_rnb, ex_valid, ex_a, ex_b, ex_wn, ex_we, ex_isload
   );
endinterface

// File: rtl/operand_fetch_fwd_sel.sv
// operand_fetch_fwd_sel: match detection and priority forwarding mux for one source operand.
// With OPERAND_FETCH_FWD_EN undefined there are no forwarding paths and any match stalls.
module operand_fetch_fwd_sel
   import operand_fetch_pkg::*;
(
   input  logic [AW-1:0] src,
   input  logic          use_src,
   input  slot_t         ex,
   input  slot_t         mem,
   input  slot_t         wb,
`ifdef OPERAND_FETCH_FWD_EN
   input  logic [DW-1:0] ex_val,
   input  logic [DW-1:0] mem_val,
   input  logic [DW-1:0] wb_val,
`endif
   input  logic [DW-1:0] rf_val,
   output logic          stall,
   output logic [DW-1:0] q
);
   logic ex_m, mem_m, wb_m;
   always_comb begin
      ex_m  = slot_match(ex, src, use_src);
      mem_m = slot_match(mem, src, use_src);
      wb_m  = slot_match(wb, src, use_src);
`ifdef OPERAND_FETCH_FWD_EN
      stall = ex_m & ex.isload;
      q     = src == REG_ZERO ? '0 : ex_m ? ex_val : mem_m ? mem_val : wb_m ? wb_val : rf_val;
`else
      stall = ex_m | mem_m | wb_m;
      q     = src == REG_ZERO ? '0 : rf_val;
`endif
   end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode-stage operand fetch with RAW hazard resolution into the ID/EX register.
// OPERAND_FETCH_FWD_EN selects full forwarding (load-use stall only); otherwise stall until no slot matches.
module operand_fetch
   import operand_fetch_pkg::*;
(
   input logic             clk,
   input logic             clrn,
   operand_fetch_if.slave  bus
);
   slot_t         ex_s, mem_s, wb_s;
   logic [DW-1:0] qa, qb, ex_a, ex_b;
   logic          stall_a, stall_b, hazard;

   operand_fetch_fwd_sel u_a (
      .src(bus.id_rs), .use_src(bus.id_use_rs), .ex(ex_s), .mem(mem_s), .wb(wb_s),
`ifdef OPERAND_FETCH_FWD_EN
      .ex_val(bus.ex_alu_res), .mem_val(bus.mem_res), .wb_val(bus.wb_d),
`endif
      .rf_val(bus.rf_qa), .stall(stall_a), .q(qa)
   );

   operand_fetch_fwd_sel u_b (
      .src(bus.id_rt), .use_src(bus.id_use_rt), .ex(ex_s), .mem(mem_s), .wb(wb_s),
`ifdef OPERAND_FETCH_FWD_EN
      .ex_val(bus.ex_alu_res), .mem_val(bus.mem_res), .wb_val(bus.wb_d),
`endif
      .rf_val(bus.rf_qb), .stall(stall_b), .q(qb)
   );

   assign hazard       = stall_a | stall_b;
   assign bus.id_ready = bus.ex_ready & ~hazard;
   assign bus.rf_rna   = bus.id_rs;
   assign bus.rf_rnb   = bus.id_rt;

   // Bubbles clear the control slot but keep the last operands.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ex_s  <= '0;
         mem_s <= '0;
         wb_s  <= '0;
         ex_a  <= '0;
         ex_b  <= '0;
      end else if (bus.ex_ready) begin
         mem_s <= ex_s;
         wb_s  <= mem_s;
         if (bus.id_valid && !hazard) begin
            ex_s <= {1'b1, bus.id_wn, bus.id_we, bus.id_isload};
            ex_a <= qa;
            ex_b <= qb;
         end else begin
            ex_s <= '0;
         end
      end
   end

   assign bus.ex_valid  = ex_s.valid;
   assign bus.ex_wn     = ex_s.wn;
   assign bus.ex_we     = ex_s.we;
   assign bus.ex_isload = ex_s.isload;
   assign bus.ex_a      = ex_a;
   assign bus.ex_b      = ex_b;
endmodule
